// File: rtl/sram_ms_pkg.sv
// Shared types and analog rail constants for the SRAM mixed-signal read path.
// Optional margin checking is enabled with SA_MARGIN_CHECK_EN.
package sram_ms_pkg;

  localparam real VDD = 1.5;
  localparam real VSS = 0.0;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    EVAL,
    DONE
  } sa_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sense_amp_array_clk_latch.sv
// One sense-amp bit: resolves BL vs BLB against the offset and latches it on strobe.
// SA_MARGIN_CHECK_EN adds the weak-read flag output.
module sa_latch_cell
  import sram_ms_pkg::*;
#(
  parameter real VOFF = 0.05
`ifdef SA_MARGIN_CHECK_EN
  ,
  parameter real VMARGIN = 0.10
`endif
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_strobe,
  input  real  i_bl,
  input  real  i_blb,
  output logic o_dout,
  output real  o_preout
`ifdef SA_MARGIN_CHECK_EN
  ,
  output logic o_weak
`endif
);

  real  w_diff;
  logic w_bit;
  logic r_dout;
  real  r_preout;

  assign w_diff = i_bl - i_blb;
  assign w_bit  = (w_diff > VOFF);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dout   <= 1'b0;
      r_preout <= VSS;
    end else if (i_strobe) begin
      r_dout   <= w_bit;
      r_preout <= w_bit ? VDD : VSS;
    end
  end

  assign o_dout   = r_dout;
  assign o_preout = r_preout;

`ifdef SA_MARGIN_CHECK_EN
  real  w_abs;
  logic r_weak;

  assign w_abs = (w_diff < 0.0) ? -w_diff : w_diff;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_weak <= 1'b0;
    end else if (i_strobe) begin
      r_weak <= (w_abs < VMARGIN);
    end
  end

  assign o_weak = r_weak;
`endif

endmodule

// File: rtl/sense_amp_array_clk.sv
// Clocked column sense-amp array: precharge/sense sequencing, column mux, req/ack.
// SA_MARGIN_CHECK_EN adds the o_margin_err weak-read flag.
module sense_amp_array_clk
  import sram_ms_pkg::*;
#(
  parameter int  COLS     = 16,
  parameter int  MUX      = 2,
  parameter int  PRE_CYC  = 2,
  parameter int  EVAL_CYC = 1,
  parameter real VOFF     = 0.05
`ifdef SA_MARGIN_CHECK_EN
  ,
  parameter real VMARGIN  = 0.10
`endif
  ,
  localparam int WORD     = COLS / MUX,
  localparam int SW       = (MUX > 1) ? $clog2(MUX) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_rd_req,
  input  logic [SW-1:0] i_col_sel,
  input  real           i_bl_rd  [0:COLS-1],
  input  real           i_blb_rd [0:COLS-1],
  output logic          o_pre_en,
  output logic          o_sae,
  output logic          o_busy,
  output logic          o_rd_ack,
  output logic [WORD-1:0] o_dout,
  output real           o_preout [0:WORD-1]
`ifdef SA_MARGIN_CHECK_EN
  ,
  output logic          o_margin_err
`endif
);

  localparam int CW = $clog2(max2(PRE_CYC, EVAL_CYC) + 1);

  sa_state_t     r_state;
  sa_state_t     w_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_d;
  logic [SW-1:0] r_sel;
  logic [SW-1:0] w_sel_d;
  logic          r_pre_en;
  logic          r_sae;
  logic          r_ack;
  logic          w_pre_d;
  logic          w_sae_d;
  logic          w_ack_d;
  logic          w_strobe;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_cnt_d  = r_cnt;
    w_sel_d  = r_sel;
    w_pre_d  = 1'b0;
    w_sae_d  = 1'b0;
    w_ack_d  = 1'b0;
    w_strobe = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_rd_req) begin
          w_next  = PRE;
          w_cnt_d = CW'(PRE_CYC - 1);
          w_sel_d = i_col_sel;
          w_pre_d = 1'b1;
        end
      end
      PRE: begin
        if (r_cnt == '0) begin
          w_next  = EVAL;
          w_cnt_d = CW'(EVAL_CYC - 1);
          w_sae_d = 1'b1;
        end else begin
          w_cnt_d = r_cnt - CW'(1);
          w_pre_d = 1'b1;
        end
      end
      EVAL: begin
        if (r_cnt == '0) begin
          w_next   = DONE;
          w_strobe = 1'b1;
          w_ack_d  = 1'b1;
        end else begin
          w_cnt_d = r_cnt - CW'(1);
          w_sae_d = 1'b1;
        end
      end
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Strobes are registered so they track the state register exactly.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_sel    <= '0;
      r_pre_en <= 1'b0;
      r_sae    <= 1'b0;
      r_ack    <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_d;
      r_sel    <= w_sel_d;
      r_pre_en <= w_pre_d;
      r_sae    <= w_sae_d;
      r_ack    <= w_ack_d;
    end
  end

  assign o_pre_en = r_pre_en;
  assign o_sae    = r_sae;
  assign o_rd_ack = r_ack;
  assign o_busy   = (r_state != IDLE);

`ifdef SA_MARGIN_CHECK_EN
  logic [WORD-1:0] w_weak;
  assign o_margin_err = |w_weak;
`endif

  for (genvar j = 0; j < WORD; j++) begin : g_bit
    real w_bl;
    real w_blb;
    int  w_col;

    assign w_col = j * MUX + ((MUX > 1) ? int'(r_sel) : 0);
    assign w_bl  = i_bl_rd[w_col];
    assign w_blb = i_blb_rd[w_col];

    sa_latch_cell #(
      .VOFF    (VOFF)
`ifdef SA_MARGIN_CHECK_EN
      ,
      .VMARGIN (VMARGIN)
`endif
    ) u_cell (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_strobe (w_strobe),
      .i_bl     (w_bl),
      .i_blb    (w_blb),
      .o_dout   (o_dout[j]),
      .o_preout (o_preout[j])
`ifdef SA_MARGIN_CHECK_EN
      ,
      .o_weak   (w_weak[j])
`endif
    );
  end

endmodule
